// File: rtl/s_axi_lite_uart_csr_pkg.sv
// Shared register map, bit positions and response codes for the UART CSR block.
package s_axi_lite_uart_csr_pkg;

  localparam logic [3:0] CSR_CTRL_OFF   = 4'h0;
  localparam logic [3:0] CSR_STATUS_OFF = 4'h4;
  localparam logic [3:0] CSR_TXDATA_OFF = 4'h8;
  localparam logic [3:0] CSR_RXDATA_OFF = 4'hC;

  localparam int CTRL_TX_EN     = 0;
  localparam int CTRL_RX_EN     = 1;
  localparam int CTRL_RX_IRQ_EN = 2;
  localparam int CTRL_TX_IRQ_EN = 3;
  localparam int CTRL_FLUSH     = 4;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_FULL    = 2;
  localparam int ST_RX_EMPTY   = 3;
  localparam int ST_RX_OVERRUN = 4;
  localparam int ST_TX_LVL_LSB = 8;
  localparam int ST_RX_LVL_LSB = 16;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Field order matches CTRL[3:0] so the register casts straight from WDATA.
  typedef struct packed {
    logic tx_irq_en;
    logic rx_irq_en;
    logic rx_en;
    logic tx_en;
  } ctrl_t;

  function automatic logic [1:0] csr_idx(input logic [3:0] off);
    return off[3:2];
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; flush has priority over push/pop.
// The count port exists only when UART_CSR_FIFO_LEVEL_EN is defined.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
`ifdef UART_CSR_FIFO_LEVEL_EN
  output logic [$clog2(DEPTH):0] count,
`endif
  output logic [WIDTH-1:0]       head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Equal low bits with differing wrap bits means the writer lapped the reader.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

`ifdef UART_CSR_FIFO_LEVEL_EN
  assign count = wr_ptr - rd_ptr;
`endif

endmodule

// File: rtl/s_axi_lite_uart_csr.sv
// AXI4-Lite CSR block for the UART: CTRL/STATUS/TXDATA/RXDATA with TX/RX FIFOs and level irq.
// Define UART_CSR_FIFO_LEVEL_EN to expose FIFO fill levels in STATUS[23:8].
module s_axi_lite_uart_csr
  import s_axi_lite_uart_csr_pkg::*;
#(
  parameter int P_S_AXI_DATA_WIDTH = 32,
  parameter int P_S_AXI_ADDR_WIDTH = 4,
  parameter int P_UART_DATA_WIDTH  = 8,
  parameter int P_FIFO_DEPTH       = 16
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [P_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [P_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [P_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [P_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [P_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  input  logic                              i_user_rx_valid,
  input  logic [P_UART_DATA_WIDTH-1:0]      i_user_rx_data,
  output logic                              o_user_tx_valid,
  output logic [P_UART_DATA_WIDTH-1:0]      o_user_tx_data,
  input  logic                              i_user_tx_ready,
  output logic                              o_irq
);

  localparam int         DW         = P_S_AXI_DATA_WIDTH;
  localparam int         UW         = P_UART_DATA_WIDTH;
  localparam logic [1:0] IDX_CTRL   = csr_idx(CSR_CTRL_OFF);
  localparam logic [1:0] IDX_STATUS = csr_idx(CSR_STATUS_OFF);
  localparam logic [1:0] IDX_TXDATA = csr_idx(CSR_TXDATA_OFF);
  localparam logic [1:0] IDX_RXDATA = csr_idx(CSR_RXDATA_OFF);

  ctrl_t          ctrl;
  logic           rx_overrun;
  logic           tx_full, tx_empty, rx_full, rx_empty;
  logic [UW-1:0]  rx_head;
  logic [1:0]     wr_idx, rd_idx;
  logic           wr_hs, rd_hs, strb0;
  logic           wr_ctrl, wr_status, wr_tx;
  logic           flush, tx_push, tx_pop, rx_push, rx_drop, rx_pop;
  logic [DW-1:0]  status;
  logic [DW-1:0]  rd_word;
  logic           rd_err;
  logic           unused_ok;

  assign wr_idx = S_AXI_AWADDR[3:2];
  assign rd_idx = S_AXI_ARADDR[3:2];
  assign strb0  = S_AXI_WSTRB[0];

  // READY is registered, so the handshake is the edge where READY is already high.
  assign wr_hs = S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_hs = S_AXI_ARREADY && S_AXI_ARVALID;

  assign wr_ctrl   = wr_hs && strb0 && (wr_idx == IDX_CTRL);
  assign wr_status = wr_hs && strb0 && (wr_idx == IDX_STATUS);
  assign wr_tx     = wr_hs && strb0 && (wr_idx == IDX_TXDATA);
  assign flush     = wr_ctrl && S_AXI_WDATA[CTRL_FLUSH];

  assign tx_push = wr_tx && !tx_full;
  assign o_user_tx_valid = ctrl.tx_en && !tx_empty;
  assign tx_pop  = o_user_tx_valid && i_user_tx_ready;

  assign rx_push = i_user_rx_valid && ctrl.rx_en && !rx_full;
  assign rx_drop = i_user_rx_valid && ctrl.rx_en && rx_full;
  assign rx_pop  = rd_hs && (rd_idx == IDX_RXDATA) && !rx_empty;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR,
                       S_AXI_WDATA, S_AXI_WSTRB};

`ifdef UART_CSR_FIFO_LEVEL_EN
  logic [$clog2(P_FIFO_DEPTH):0] tx_count;
  logic [$clog2(P_FIFO_DEPTH):0] rx_count;
`endif

  uart_sync_fifo #(.WIDTH(UW), .DEPTH(P_FIFO_DEPTH)) u_tx_fifo (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_ARESETN),
    .push  (tx_push),
    .wdata (S_AXI_WDATA[UW-1:0]),
    .pop   (tx_pop),
    .flush (flush),
    .full  (tx_full),
    .empty (tx_empty),
`ifdef UART_CSR_FIFO_LEVEL_EN
    .count (tx_count),
`endif
    .head  (o_user_tx_data)
  );

  uart_sync_fifo #(.WIDTH(UW), .DEPTH(P_FIFO_DEPTH)) u_rx_fifo (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_ARESETN),
    .push  (rx_push),
    .wdata (i_user_rx_data),
    .pop   (rx_pop),
    .flush (flush),
    .full  (rx_full),
    .empty (rx_empty),
`ifdef UART_CSR_FIFO_LEVEL_EN
    .count (rx_count),
`endif
    .head  (rx_head)
  );

  always_comb begin
    status                = '0;
    status[ST_TX_FULL]    = tx_full;
    status[ST_TX_EMPTY]   = tx_empty;
    status[ST_RX_FULL]    = rx_full;
    status[ST_RX_EMPTY]   = rx_empty;
    status[ST_RX_OVERRUN] = rx_overrun;
`ifdef UART_CSR_FIFO_LEVEL_EN
    status[ST_TX_LVL_LSB +: 8] = 8'(tx_count);
    status[ST_RX_LVL_LSB +: 8] = 8'(rx_count);
`endif
  end

  always_comb begin
    rd_word = '0;
    rd_err  = 1'b0;
    case (rd_idx)
      IDX_CTRL:   rd_word[3:0] = ctrl;
      IDX_STATUS: rd_word      = status;
      IDX_RXDATA: begin
        if (rx_empty) rd_err = 1'b1;
        else          rd_word[UW-1:0] = rx_head;
      end
      default:    rd_word = '0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RRESP   <= RESP_OKAY;
      S_AXI_RDATA   <= '0;
      ctrl          <= '0;
      rx_overrun    <= 1'b0;
      o_irq         <= 1'b0;
    end else begin
      S_AXI_AWREADY <= S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID && !S_AXI_AWREADY;
      S_AXI_WREADY  <= S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID && !S_AXI_AWREADY;
      S_AXI_ARREADY <= S_AXI_ARVALID && !S_AXI_RVALID && !S_AXI_ARREADY;

      if (wr_hs) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= (wr_tx && tx_full) ? RESP_SLVERR : RESP_OKAY;
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end

      if (rd_hs) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_word;
        S_AXI_RRESP  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end

      if (wr_ctrl) ctrl <= ctrl_t'(S_AXI_WDATA[3:0]);

      // A new overrun beats a same-cycle W1C so the event is never lost.
      if (flush)                                           rx_overrun <= 1'b0;
      else if (rx_drop)                                    rx_overrun <= 1'b1;
      else if (wr_status && S_AXI_WDATA[ST_RX_OVERRUN])    rx_overrun <= 1'b0;

      o_irq <= (ctrl.rx_irq_en && !rx_empty) || (ctrl.tx_irq_en && tx_empty) || rx_overrun;
    end
  end

endmodule

// File: tb/tb_s_axi_lite_uart_csr.sv
// Directed bench for s_axi_lite_uart_csr (default build, level readback disabled).
module tb_s_axi_lite_uart_csr;

  logic        clk;
  logic        rst_n;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  s_axi_lite_uart_csr dut (
    .S_AXI_ACLK      (clk),
    .S_AXI_ARESETN   (rst_n),
    .S_AXI_AWADDR    (awaddr),
    .S_AXI_AWPROT    (awprot),
    .S_AXI_AWVALID   (awvalid),
    .S_AXI_AWREADY   (awready),
    .S_AXI_WDATA     (wdata),
    .S_AXI_WSTRB     (wstrb),
    .S_AXI_WVALID    (wvalid),
    .S_AXI_WREADY    (wready),
    .S_AXI_BRESP     (bresp),
    .S_AXI_BVALID    (bvalid),
    .S_AXI_BREADY    (bready),
    .S_AXI_ARADDR    (araddr),
    .S_AXI_ARPROT    (arprot),
    .S_AXI_ARVALID   (arvalid),
    .S_AXI_ARREADY   (arready),
    .S_AXI_RDATA     (rdata),
    .S_AXI_RRESP     (rresp),
    .S_AXI_RVALID    (rvalid),
    .S_AXI_RREADY    (rready),
    .i_user_rx_valid (rx_valid),
    .i_user_rx_data  (rx_data),
    .o_user_tx_valid (tx_valid),
    .o_user_tx_data  (tx_data),
    .i_user_tx_ready (tx_ready),
    .o_irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=still_running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input bit pop_at_hs, input bit hold_b, output logic [1:0] resp);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = !hold_b;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (awready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      check_eq("aw_timeout", 32'd0, 32'd1);
      awvalid = 1'b0; wvalid = 1'b0; resp = 2'b11;
      return;
    end
    check_eq("wready_pair", {31'd0, wready}, 32'd1);
    if (pop_at_hs) tx_ready = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    if (pop_at_hs) tx_ready = 1'b0;
    check_eq("b_latency", {31'd0, bvalid}, 32'd1);
    resp = bresp;
    if (!hold_b) begin
      @(negedge clk);
      check_eq("b_release", {31'd0, bvalid}, 32'd0);
    end
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      check_eq("ar_timeout", 32'd0, 32'd1);
      arvalid = 1'b0; data = 32'hDEAD_BEEF; resp = 2'b11;
      return;
    end
    @(negedge clk);
    arvalid = 1'b0;
    check_eq("r_latency", {31'd0, rvalid}, 32'd1);
    data = rdata;
    resp = rresp;
    @(negedge clk);
    check_eq("r_release", {31'd0, rvalid}, 32'd0);
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = d;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic tx_pulse();
    @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  logic [31:0] d;
  logic [1:0]  r;

  initial begin
    rst_n = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: reset state
    check_eq("rst_ctrl_outs", {25'd0, awready, wready, bvalid, arready, rvalid, tx_valid, irq}, 32'd0);
    check_eq("rst_resp", {28'd0, bresp, rresp}, 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    axi_read(4'h4, d, r);
    check_eq("t1_status", d, 32'h0000_000A);
    check_eq("t1_rresp", {30'd0, r}, 32'd0);
    check_eq("t1_irq", {31'd0, irq}, 32'd0);

    // 2: single TX character with the engine stalled, then popped
    axi_write(4'h0, 32'h1, 4'hF, 0, 0, r);
    axi_write(4'h8, 32'h41, 4'hF, 0, 0, r);
    check_eq("t2_bresp", {30'd0, r}, 32'd0);
    check_eq("t2_tx_valid", {31'd0, tx_valid}, 32'd1);
    check_eq("t2_tx_data", {24'd0, tx_data}, 32'h41);
    tx_pulse();
    check_eq("t2_tx_popped", {31'd0, tx_valid}, 32'd0);
    axi_write(4'h8, 32'h42, 4'h0, 0, 0, r);
    check_eq("t2_nostrb_bresp", {30'd0, r}, 32'd0);
    check_eq("t2_nostrb_nopush", {31'd0, tx_valid}, 32'd0);
    axi_read(4'h8, d, r);
    check_eq("t2_txdata_reads0", d, 32'd0);

    // 3: overfill the TX FIFO
    axi_write(4'h0, 32'h0, 4'hF, 0, 0, r);
    for (int i = 0; i < 17; i++) begin
      axi_write(4'h8, 32'h60 + i, 4'hF, 0, 0, r);
      check_eq($sformatf("t3_bresp_%0d", i), {30'd0, r}, (i < 16) ? 32'd0 : 32'd2);
    end
    axi_read(4'h4, d, r);
    check_eq("t3_status_full", d, 32'h0000_0009);
    axi_write(4'h0, 32'h1, 4'hF, 0, 0, r);
    check_eq("t3_head0", {24'd0, tx_data}, 32'h60);
    tx_pulse();
    check_eq("t3_head1", {24'd0, tx_data}, 32'h61);
    axi_write(4'h0, 32'h10, 4'hF, 0, 0, r);
    axi_read(4'h4, d, r);
    check_eq("t3_status_flushed", d, 32'h0000_000A);

    // 4: overfill the RX FIFO, drain it, clear overrun
    axi_write(4'h0, 32'h2, 4'hF, 0, 0, r);
    for (int i = 0; i < 17; i++) rx_pulse(8'(i));
    axi_read(4'h4, d, r);
    check_eq("t4_status_overrun", d, 32'h0000_0016);
    check_eq("t4_irq_overrun", {31'd0, irq}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      axi_read(4'hC, d, r);
      check_eq($sformatf("t4_rxdata_%0d", i), d, 32'(i));
      check_eq($sformatf("t4_rresp_%0d", i), {30'd0, r}, 32'd0);
    end
    axi_read(4'hC, d, r);
    check_eq("t4_empty_rdata", d, 32'd0);
    check_eq("t4_empty_rresp", {30'd0, r}, 32'd2);
    axi_read(4'h4, d, r);
    check_eq("t4_status_sticky", d, 32'h0000_001A);
    axi_write(4'h4, 32'h10, 4'hF, 0, 0, r);
    check_eq("t4_w1c_bresp", {30'd0, r}, 32'd0);
    axi_read(4'h4, d, r);
    check_eq("t4_status_cleared", d, 32'h0000_000A);
    check_eq("t4_irq_cleared", {31'd0, irq}, 32'd0);

    // rx_en cleared: characters ignored
    axi_write(4'h0, 32'h0, 4'hF, 0, 0, r);
    rx_pulse(8'h77);
    axi_read(4'h4, d, r);
    check_eq("t4_rx_disabled", d, 32'h0000_000A);

    // 5: interrupt sources
    axi_write(4'h0, 32'h6, 4'hF, 0, 0, r);
    check_eq("t5_irq_idle", {31'd0, irq}, 32'd0);
    rx_pulse(8'h55);
    repeat (2) @(negedge clk);
    check_eq("t5_irq_rx", {31'd0, irq}, 32'd1);
    axi_read(4'hC, d, r);
    check_eq("t5_rxdata", d, 32'h55);
    repeat (2) @(negedge clk);
    check_eq("t5_irq_rx_clear", {31'd0, irq}, 32'd0);
    axi_write(4'h0, 32'h8, 4'hF, 0, 0, r);
    repeat (2) @(negedge clk);
    check_eq("t5_irq_tx_empty", {31'd0, irq}, 32'd1);

    // 6: flush racing a user pop, then reset with a pending B response
    axi_write(4'h0, 32'h3, 4'hF, 0, 0, r);
    for (int i = 0; i < 5; i++) axi_write(4'h8, 32'hA0 + i, 4'hF, 0, 0, r);
    rx_pulse(8'h33);
    axi_read(4'h4, d, r);
    check_eq("t6_status_busy", d, 32'h0000_0000);
    axi_write(4'h0, 32'h10, 4'hF, 1, 0, r);
    axi_read(4'h4, d, r);
    check_eq("t6_status_flush", d, 32'h0000_000A);
    axi_read(4'h0, d, r);
    check_eq("t6_ctrl_reads0", d, 32'd0);
    check_eq("t6_tx_valid", {31'd0, tx_valid}, 32'd0);

    axi_write(4'h0, 32'h1, 4'hF, 0, 1, r);
    check_eq("t6_bvalid_held", {31'd0, bvalid}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_eq("t6_bvalid_async", {31'd0, bvalid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t6_no_replay", {31'd0, bvalid}, 32'd0);
    axi_read(4'h0, d, r);
    check_eq("t6_ctrl_after_rst", d, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
